// File: rtl/segre_mext_unit.sv
// rtl/segre_mext_unit.sv - multi-cycle RISC-V M-extension execution unit
//
// Executes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU per handshake.
// Multiplies finish in two cycles. Divides and remainders run a radix-2
// restoring loop of DATA_W iterations. The result is held until writeback
// takes it.
//
// Optional build macro: SEGRE_MEXT_DIV_EARLY_EN
//   When defined, divide-by-zero and signed-overflow divides skip the loop
//   and complete one cycle after accept. The result values do not change.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        op offered by ID
//   opcode_i       M-ext operation
//   src_a_i/b_i    rs1/rs2 operand values
//   rf_waddr_i     destination register of the offered op
//   flush_i        abort any in-flight op and drop its result
//   wb_ready_i     writeback consumes the result this cycle
//   busy_o         unit not idle; no op is accepted
//   busy_waddr_o   rd of the in-flight op while busy, else 0
//   valid_o        result valid
//   rf_we_o        register-file write enable (equals valid_o)
//   rf_waddr_o     rd of the result
//   rd_data_o      result value

package segre_mext_pkg;
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } m_ext_opcode_e;
endpackage

module segre_mext_unit
    import segre_mext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  m_ext_opcode_e     opcode_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic [ADDR_W-1:0] rf_waddr_i,
    input  logic              flush_i,
    input  logic              wb_ready_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] busy_waddr_o,
    output logic              valid_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_INT  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    state_e            state;
    m_ext_opcode_e     op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvsr;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;
    logic              div_ovf;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] waddr_q;

    // ---------------- accept-time decode ----------------
    logic              in_is_mul;
    logic              in_signed_div;
    logic [DATA_W-1:0] in_mag_a;
    logic [DATA_W-1:0] in_mag_b;
    logic              in_div_zero;
    logic              in_div_ovf;

    assign in_is_mul     = (opcode_i == M_MUL)  || (opcode_i == M_MULH) ||
                           (opcode_i == M_MULHSU) || (opcode_i == M_MULHU);
    assign in_signed_div = (opcode_i == M_DIV) || (opcode_i == M_REM);
    assign in_mag_a      = (in_signed_div && src_a_i[DATA_W-1]) ? (~src_a_i + 1'b1) : src_a_i;
    assign in_mag_b      = (in_signed_div && src_b_i[DATA_W-1]) ? (~src_b_i + 1'b1) : src_b_i;
    assign in_div_zero   = !in_is_mul && (src_b_i == '0);
    assign in_div_ovf    = in_signed_div && (src_a_i == MIN_INT) && (src_b_i == '1);

    // ---------------- multiplier ----------------
    // Operands are extended to 2*DATA_W bits; the low 2*DATA_W bits of the
    // two's-complement product are exact for every sign combination.
    logic              a_sext;
    logic              b_sext;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] mul_result;

    assign a_sext     = (op == M_MULH) || (op == M_MULHSU);
    assign b_sext     = (op == M_MULH);
    assign a_ext      = {{DATA_W{a_sext & op_a[DATA_W-1]}}, op_a};
    assign b_ext      = {{DATA_W{b_sext & op_b[DATA_W-1]}}, op_b};
    assign prod       = a_ext * b_ext;
    assign mul_result = (op == M_MUL) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];

    // ---------------- restoring divider step ----------------
    // The partial remainder stays below the divisor, so DATA_W+1 bits are
    // enough for the trial subtraction and its top bit is the borrow.
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] q_fix;
    logic [DATA_W-1:0] r_fix;
    logic              is_rem;
    logic [DATA_W-1:0] div_result;
    logic              early_done;

    assign trial    = {rem, quo[DATA_W-1]} - {1'b0, dvsr};
    assign rem_next = trial[DATA_W] ? {rem[DATA_W-2:0], quo[DATA_W-1]} : trial[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], ~trial[DATA_W]};
    assign q_fix    = neg_q ? (~quo_next + 1'b1) : quo_next;
    assign r_fix    = neg_r ? (~rem_next + 1'b1) : rem_next;
    assign is_rem   = (op == M_REM) || (op == M_REMU);

    always_comb begin
        div_result = is_rem ? r_fix : q_fix;
        if (div_zero) begin
            div_result = is_rem ? op_a : '1;
        end else if (div_ovf) begin
            div_result = is_rem ? '0 : MIN_INT;
        end
    end

`ifdef SEGRE_MEXT_DIV_EARLY_EN
    assign early_done = div_zero || div_ovf;
`else
    assign early_done = 1'b0;
`endif

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            op       <= M_MUL;
            op_a     <= '0;
            op_b     <= '0;
            rd       <= '0;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            waddr_q  <= '0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        op       <= opcode_i;
                        op_a     <= src_a_i;
                        op_b     <= src_b_i;
                        rd       <= rf_waddr_i;
                        quo      <= in_mag_a;
                        rem      <= '0;
                        dvsr     <= in_mag_b;
                        cnt      <= '0;
                        neg_q    <= in_signed_div && (src_a_i[DATA_W-1] ^ src_b_i[DATA_W-1]);
                        neg_r    <= in_signed_div && src_a_i[DATA_W-1];
                        div_zero <= in_div_zero;
                        div_ovf  <= in_div_ovf;
                        state    <= in_is_mul ? ST_MUL : ST_DIV;
                    end
                end
                ST_MUL: begin
                    data_q  <= mul_result;
                    waddr_q <= rd;
                    valid_q <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (early_done || (cnt == CNT_LAST)) begin
                        data_q  <= div_result;
                        waddr_q <= rd;
                        valid_q <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (wb_ready_i) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = (state != ST_IDLE);
    assign busy_waddr_o = busy_o ? rd : '0;
    assign valid_o      = valid_q;
    assign rf_we_o      = valid_q;
    assign rf_waddr_o   = waddr_q;
    assign rd_data_o    = data_q;

endmodule
